// File: rtl/led_effects.sv
// LED effect engine: blink, chase and game-over effects for the LED bar.
// Ports: clk, rst_n (async low), perfect/hit pulses, dead level, led, busy.
module led_effects #(
    parameter int NUM_LEDS    = 8,
    parameter int HALF_PERIOD = 5000000,
    parameter int BLINK_TIMES = 3,
    parameter int STEP_PERIOD = 2500000,
    parameter int CNT_W       = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                perfect,
    input  logic                hit,
    input  logic                dead,
    output logic [NUM_LEDS-1:0] led,
    output logic                busy
);

    localparam int PW = (BLINK_TIMES > 1) ? $clog2(BLINK_TIMES) : 1;
    localparam int IW = $clog2(NUM_LEDS);

    localparam logic [CNT_W-1:0] HALF_T    = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] STEP_T    = CNT_W'(STEP_PERIOD - 1);
    localparam logic [PW-1:0]    LAST_PAIR = PW'(BLINK_TIMES - 1);
    localparam logic [IW-1:0]    LAST_IDX  = IW'(NUM_LEDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLINK,
        S_CHASE,
        S_DEAD
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    timer_q, timer_d;
    logic [PW-1:0]       pair_q, pair_d;
    logic                on_q, on_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic                busy_q, busy_d;
    logic                go_blink, go_chase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            pair_q  <= '0;
            on_q    <= 1'b0;
            idx_q   <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pair_q  <= pair_d;
            on_q    <= on_d;
            idx_q   <= idx_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        pair_d   = pair_q;
        on_d     = on_q;
        idx_d    = idx_q;
        led_d    = led_q;
        go_blink = 1'b0;
        go_chase = 1'b0;

        if (dead) begin
            state_d = S_DEAD;
            timer_d = '0;
            pair_d  = '0;
            on_d    = 1'b0;
            idx_d   = '0;
            led_d   = '1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    go_blink = perfect;
                    go_chase = hit;
                end
                S_BLINK: begin
                    // hit is ignored while blinking
                    if (perfect) begin
                        go_blink = 1'b1;
                    end else if (timer_q != '0) begin
                        timer_d = timer_q - CNT_W'(1);
                    end else if (on_q) begin
                        on_d    = 1'b0;
                        led_d   = '0;
                        timer_d = HALF_T;
                    end else if (pair_q == LAST_PAIR) begin
                        state_d = S_IDLE;
                        pair_d  = '0;
                        led_d   = '0;
                    end else begin
                        pair_d  = pair_q + PW'(1);
                        on_d    = 1'b1;
                        led_d   = '1;
                        timer_d = HALF_T;
                    end
                end
                S_CHASE: begin
                    if (perfect || hit) begin
                        go_blink = perfect;
                        go_chase = hit;
                    end else if (timer_q != '0) begin
                        timer_d = timer_q - CNT_W'(1);
                    end else if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        led_d   = '0;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        led_d   = led_q << 1;
                        timer_d = STEP_T;
                    end
                end
                S_DEAD: begin
                    // dead just fell: pulses this cycle are dropped too
                    state_d = S_IDLE;
                    led_d   = '0;
                end
            endcase

            // perfect outranks hit when both arrive together
            if (go_blink) begin
                state_d = S_BLINK;
                timer_d = HALF_T;
                pair_d  = '0;
                on_d    = 1'b1;
                idx_d   = '0;
                led_d   = '1;
            end else if (go_chase) begin
                state_d = S_CHASE;
                timer_d = STEP_T;
                pair_d  = '0;
                on_d    = 1'b0;
                idx_d   = '0;
                led_d   = NUM_LEDS'(1);
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    assign led  = led_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_led_effects.sv
// Testbench for led_effects: scoreboard of expected led/busy per clock.
// Small parameters: 4 LEDs, half period 3, two blinks, step period 2.
module tb_led_effects;

    typedef struct packed {
        logic [3:0] led;
        logic       busy;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       perfect;
    logic       hit;
    logic       dead;
    logic [3:0] led;
    logic       busy;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    led_effects #(
        .NUM_LEDS   (4),
        .HALF_PERIOD(3),
        .BLINK_TIMES(2),
        .STEP_PERIOD(2),
        .CNT_W      (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .perfect(perfect),
        .hit    (hit),
        .dead   (dead),
        .led    (led),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: sim time expired, required finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] act,
                            input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Blink: F for 3, 0 for 3, repeated twice.
    function automatic logic [3:0] blink_led(input int i);
        return ((i / 3) % 2 == 0) ? 4'hF : 4'h0;
    endfunction

    // Chase: each bit for 2 cycles, bit 0 first.
    function automatic logic [3:0] chase_led(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return one << (i / 2);
    endfunction

    // Drive inputs for one edge, queue the expected post-edge output,
    // then compare once the DUT has registered it.
    task automatic step(input string tag, input logic p, input logic h,
                        input logic d, input logic [3:0] el,
                        input logic eb);
        exp_t e;
        perfect = p;
        hit     = h;
        dead    = d;
        e.led   = el;
        e.busy  = eb;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_eq({tag, "_led"}, 32'(led), 32'(e.led));
            check_eq({tag, "_busy"}, 32'(busy), 32'(e.busy));
        end
    endtask

    task automatic idle_steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        perfect  = 1'b0;
        hit      = 1'b0;
        dead     = 1'b0;

        #12;
        check_eq("reset_led", 32'(led), 32'h0);
        check_eq("reset_busy", 32'(busy), 32'h0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle_steps("idle0", 2);

        // 1: single blink, busy exactly 12 cycles
        step("t1", 1'b1, 1'b0, 1'b0, blink_led(0), 1'b1);
        for (int i = 1; i < 12; i++)
            step("t1", 1'b0, 1'b0, 1'b0, blink_led(i), 1'b1);
        idle_steps("t1_end", 2);

        // 2: chase, busy 8 cycles
        step("t2", 1'b0, 1'b1, 1'b0, chase_led(0), 1'b1);
        for (int i = 1; i < 8; i++)
            step("t2", 1'b0, 1'b0, 1'b0, chase_led(i), 1'b1);
        idle_steps("t2_end", 2);

        // 3: chase aborted by perfect; hit during blink ignored
        step("t3c", 1'b0, 1'b1, 1'b0, chase_led(0), 1'b1);
        for (int i = 1; i < 3; i++)
            step("t3c", 1'b0, 1'b0, 1'b0, chase_led(i), 1'b1);
        step("t3b", 1'b1, 1'b0, 1'b0, blink_led(0), 1'b1);
        for (int i = 1; i < 12; i++)
            step("t3b", 1'b0, (i == 5), 1'b0, blink_led(i), 1'b1);
        idle_steps("t3_end", 2);

        // 4: dead mid-blink with pulses inside, then release
        step("t4b", 1'b1, 1'b0, 1'b0, blink_led(0), 1'b1);
        for (int i = 1; i < 4; i++)
            step("t4b", 1'b0, 1'b0, 1'b0, blink_led(i), 1'b1);
        step("t4d", 1'b0, 1'b0, 1'b1, 4'hF, 1'b1);
        step("t4d", 1'b1, 1'b0, 1'b1, 4'hF, 1'b1);
        step("t4d", 1'b0, 1'b0, 1'b1, 4'hF, 1'b1);
        step("t4d", 1'b0, 1'b1, 1'b1, 4'hF, 1'b1);
        step("t4d", 1'b1, 1'b1, 1'b1, 4'hF, 1'b1);
        idle_steps("t4_end", 4);

        // 5: perfect+hit together, then restart in blink cycle 4
        step("t5", 1'b1, 1'b1, 1'b0, blink_led(0), 1'b1);
        for (int i = 1; i < 3; i++)
            step("t5", 1'b0, 1'b0, 1'b0, blink_led(i), 1'b1);
        step("t5r", 1'b1, 1'b0, 1'b0, blink_led(0), 1'b1);
        for (int i = 1; i < 12; i++)
            step("t5r", 1'b0, 1'b0, 1'b0, blink_led(i), 1'b1);
        idle_steps("t5_end", 3);

        // 6: asynchronous reset mid-chase
        step("t6", 1'b0, 1'b1, 1'b0, chase_led(0), 1'b1);
        for (int i = 1; i < 3; i++)
            step("t6", 1'b0, 1'b0, 1'b0, chase_led(i), 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check_eq("t6_rst_led", 32'(led), 32'h0);
        check_eq("t6_rst_busy", 32'(busy), 32'h0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle_steps("t6_idle", 3);
        step("t6_alive", 1'b0, 1'b1, 1'b0, chase_led(0), 1'b1);
        step("t6_alive", 1'b0, 1'b0, 1'b0, chase_led(1), 1'b1);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
